// File: rtl/py_rxword_packer_if.sv
// Receive payload word-packer bus: decoded bit stream in, RAM write port and status out.
// Latency: none, this is a plain signal bundle.
// Backpressure: none. Strobes are fire-and-forget and the RAM side always accepts.
interface py_rxword_packer_if #(
    parameter int WORD_W = 32,
    parameter int ADDR_W = 8
);
    logic                  py_datvalid_p;
    logic                  bit_en;
    logic                  pydecdatout;
    logic                  dec_py_st_p;
    logic                  dec_py_endp;
    logic                  abort_p;
    logic [WORD_W-1:0]     rxpydin;
    logic [ADDR_W-1:0]     rxpyadr;
    logic                  rxpydin_valid_p_wr;
    logic [WORD_W/8-1:0]   rxpy_be;
    logic [12:0]           rx_bitcnt;
    logic                  rx_done_p;
    logic                  rx_overflow;
    logic                  busy;

    // Upstream decoder side: drives the bit stream and observes the write port.
    modport master (
        output py_datvalid_p, bit_en, pydecdatout, dec_py_st_p, dec_py_endp, abort_p,
        input  rxpydin, rxpyadr, rxpydin_valid_p_wr, rxpy_be, rx_bitcnt,
               rx_done_p, rx_overflow, busy
    );

    // Packer side.
    modport slave (
        input  py_datvalid_p, bit_en, pydecdatout, dec_py_st_p, dec_py_endp, abort_p,
        output rxpydin, rxpyadr, rxpydin_valid_p_wr, rxpy_be, rx_bitcnt,
               rx_done_p, rx_overflow, busy
    );
endinterface

// File: rtl/py_rxword_packer.sv
// Packs decoded payload bits LSB-first into WORD_W words and writes them to the RX payload RAM.
// Latency: write 1 cycle after the word-completing bit; final word after P pad cycles, done 1 cycle later.
// Backpressure: none. Bits arrive on strobes at least 2 cycles apart and every write is taken at once.
module py_rxword_packer #(
    parameter int WORD_W = 32,
    parameter int ADDR_W = 8,
    parameter int DEPTH  = 256
) (
    input  logic              clk_6M,
    input  logic              rstz,
    py_rxword_packer_if.slave rx
);
    localparam int                LW       = $clog2(WORD_W);
    localparam int                BE_W     = WORD_W / 8;
    localparam logic [ADDR_W-1:0] LAST_ADR = ADDR_W'(DEPTH - 1);
    localparam logic [12:0]       CNT_MAX  = 13'h1FFF;

    typedef enum logic [2:0] {S_IDLE, S_COLLECT, S_PAD, S_WRITE, S_DONE} state_t;

    state_t            r_state;
    state_t            w_next;
    logic [WORD_W-1:0] r_dat;
    logic [ADDR_W-1:0] r_adr;
    logic [12:0]       r_bitcnt;
    logic [LW-1:0]     r_pos;      // slot the next bit (real or pad) lands in, within the word
    logic [LW:0]       r_nreal;    // real bits in the word being built, drives the byte enables
    logic              r_last;     // end of packet seen, the pending write is the final one
    logic              r_wrap;     // last buffer slot already written in this packet
    logic              r_ovf;
    logic              w_accept;
    logic              w_wr;
    logic              w_done;
    logic              w_busy;
    logic [BE_W-1:0]   w_be;

    assign w_accept = rx.py_datvalid_p & rx.bit_en & (r_state == S_COLLECT);

    // State register.
    always_ff @(posedge clk_6M or negedge rstz) begin
        if (!rstz) r_state <= S_IDLE;
        else       r_state <= w_next;
    end

    // Next state: abort beats restart, restart beats everything else; a full slot counter ends the word.
    always_comb begin
        w_next = r_state;
        if (rx.abort_p) begin
            w_next = S_IDLE;
        end else if (rx.dec_py_st_p) begin
            w_next = S_COLLECT;
        end else begin
            case (r_state)
                S_IDLE:    w_next = S_IDLE;
                S_COLLECT: begin
                    if (w_accept) begin
                        if (&r_pos)              w_next = S_WRITE;
                        else if (rx.dec_py_endp) w_next = S_PAD;
                    end
                end
                S_PAD:     if (&r_pos) w_next = S_WRITE;
                S_WRITE:   w_next = r_last ? S_DONE : S_COLLECT;
                S_DONE:    w_next = S_IDLE;
                default:   w_next = S_IDLE;
            endcase
        end
    end

    // Outputs decoded from state; writes past the last buffer slot are swallowed.
    always_comb begin
        w_wr   = 1'b0;
        w_done = 1'b0;
        w_busy = (r_state != S_IDLE);
        w_be   = '0;
        case (r_state)
            S_WRITE: begin
                w_wr = ~r_wrap;
                for (int b = 0; b < BE_W; b++) begin
                    w_be[b] = (int'(r_nreal) > 8 * b);
                end
            end
            S_DONE:  w_done = 1'b1;
            default: w_done = 1'b0;
        endcase
    end

    // Datapath: shift register, counters and overflow guard. Abort freezes everything until the next start.
    always_ff @(posedge clk_6M or negedge rstz) begin
        if (!rstz) begin
            r_dat    <= '0;
            r_adr    <= '0;
            r_bitcnt <= '0;
            r_pos    <= '0;
            r_nreal  <= '0;
            r_last   <= 1'b0;
            r_wrap   <= 1'b0;
            r_ovf    <= 1'b0;
        end else if (!rx.abort_p) begin
            if (rx.dec_py_st_p) begin
                r_dat    <= '0;
                r_adr    <= '0;
                r_bitcnt <= '0;
                r_pos    <= '0;
                r_nreal  <= '0;
                r_last   <= 1'b0;
                r_wrap   <= 1'b0;
                r_ovf    <= 1'b0;
            end else begin
                case (r_state)
                    S_COLLECT: begin
                        if (w_accept) begin
                            r_dat   <= {rx.pydecdatout, r_dat[WORD_W-1:1]};
                            r_pos   <= r_pos + 1'b1;
                            r_nreal <= r_nreal + 1'b1;
                            if (r_bitcnt != CNT_MAX) r_bitcnt <= r_bitcnt + 13'd1;
                            if (rx.dec_py_endp)      r_last   <= 1'b1;
                        end
                    end
                    S_PAD: begin
                        r_dat <= {1'b0, r_dat[WORD_W-1:1]};
                        r_pos <= r_pos + 1'b1;
                    end
                    S_WRITE: begin
                        r_nreal <= '0;
                        if (r_wrap)                r_ovf  <= 1'b1;
                        else if (r_adr == LAST_ADR) r_wrap <= 1'b1;
                        else                        r_adr  <= r_adr + 1'b1;
                    end
                    default: r_pos <= r_pos;
                endcase
            end
        end
    end

    assign rx.rxpydin            = r_dat;
    assign rx.rxpyadr            = r_adr;
    assign rx.rxpydin_valid_p_wr = w_wr;
    assign rx.rxpy_be            = w_be;
    assign rx.rx_bitcnt          = r_bitcnt;
    assign rx.rx_done_p          = w_done;
    assign rx.rx_overflow        = r_ovf;
    assign rx.busy               = w_busy;
endmodule
